// File: rtl/cim_seq_ctrl.sv
// rtl/cim_seq_ctrl.sv - instruction sequencer issuing into the CIM pipeline
module cim_seq_ctrl #(
    parameter int IW      = 16,
    parameter int AW      = 8,
    parameter int CIM_CYC = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_pc,
    input  logic          hold,
    output logic [AW-1:0] pc,
    input  logic [IW-1:0] instr_in,
    output logic          issue_valid,
    output logic [IW-1:0] issue_instr,
    output logic          slide_en,
    output logic          busy,
    output logic          done
);
    localparam int OW = (CIM_CYC > 2) ? $clog2(CIM_CYC) : 1;
    localparam logic [OW-1:0] OCC_INIT = OW'(CIM_CYC - 1);
    localparam logic [2:0] OP_CIM  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_CIM_WAIT = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] pc_n;
    logic          issue_valid_n, slide_en_n, busy_n, done_n;
    logic [IW-1:0] issue_instr_n;
    logic [2:0]    rep, rep_n;
    logic [OW-1:0] occ, occ_n;
    logic [IW-1:0] cim_instr, cim_instr_n;
    logic [2:0]    opcode;

    assign opcode = instr_in[IW-1 -: 3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            issue_valid <= 1'b0;
            issue_instr <= '0;
            slide_en    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rep         <= '0;
            occ         <= '0;
            cim_instr   <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            issue_valid <= issue_valid_n;
            issue_instr <= issue_instr_n;
            slide_en    <= slide_en_n;
            busy        <= busy_n;
            done        <= done_n;
            rep         <= rep_n;
            occ         <= occ_n;
            cim_instr   <= cim_instr_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        issue_valid_n = 1'b0;
        issue_instr_n = issue_instr;
        slide_en_n    = 1'b0;
        busy_n        = busy;
        done_n        = 1'b0;
        rep_n         = rep;
        occ_n         = occ;
        cim_instr_n   = cim_instr;
        case (state)
            S_IDLE: begin
                if (start) begin
                    pc_n    = start_pc;
                    busy_n  = 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: state_n = S_EXEC;
            S_EXEC: begin
                // pc is frozen under hold, so instr_in stays valid for the retry
                if (!hold) begin
                    if (opcode == OP_HALT) begin
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = S_IDLE;
                    end else begin
                        issue_valid_n = 1'b1;
                        issue_instr_n = instr_in;
                        pc_n          = pc + AW'(1);
                        if (opcode == OP_CIM) begin
                            rep_n       = instr_in[IW-4 -: 3];
                            occ_n       = OCC_INIT;
                            cim_instr_n = instr_in;
                            state_n     = S_CIM_WAIT;
                        end else begin
                            state_n = S_FETCH;
                        end
                    end
                end
            end
            S_CIM_WAIT: begin
                // occupancy counts down regardless of hold; only the reissue waits
                if (occ != '0) begin
                    occ_n = occ - OW'(1);
                end else if (rep == '0) begin
                    state_n = S_FETCH;
                end else if (!hold) begin
                    issue_valid_n = 1'b1;
                    issue_instr_n = cim_instr;
                    slide_en_n    = 1'b1;
                    rep_n         = rep - 3'd1;
                    occ_n         = OCC_INIT;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_cim_seq_ctrl.sv
// tb/tb_cim_seq_ctrl.sv - scoreboard bench for cim_seq_ctrl
module tb_cim_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_pc = '0;
    logic        hold = 1'b0;
    logic [7:0]  pc;
    logic [15:0] instr_in = '0;
    logic        issue_valid;
    logic [15:0] issue_instr;
    logic        slide_en;
    logic        busy;
    logic        done;

    cim_seq_ctrl #(.IW(16), .AW(8), .CIM_CYC(4)) dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .hold(hold),
        .pc(pc), .instr_in(instr_in), .issue_valid(issue_valid),
        .issue_instr(issue_instr), .slide_en(slide_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    always @(posedge clk) instr_in <= mem[pc];

    int cyc = 0;
    int t0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        bit          is_done;
        int          rel;
        logic [15:0] instr;
        bit          slide;
        logic [7:0]  pc;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  spc;
        int          n_issue;
        int          done_rel;
    } vec_t;

    localparam logic [15:0] HALT = 16'hE000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (issue_valid || done)) begin
            nvec++;
            if (sb.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_event: rel=%0d iv=%0b done=%0b instr=%h", cyc - t0, issue_valid, done, issue_instr);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if (done !== e.is_done || issue_valid !== !e.is_done || (cyc - t0) != e.rel ||
                    pc !== e.pc || busy !== !e.is_done ||
                    (!e.is_done && (issue_instr !== e.instr || slide_en !== e.slide))) begin
                    nerr++;
                    $display("FAIL event: got rel=%0d done=%0b iv=%0b instr=%h slide=%0b pc=%h busy=%0b expected rel=%0d done=%0b instr=%h slide=%0b pc=%h",
                             cyc - t0, done, issue_valid, issue_instr, slide_en, pc, busy,
                             e.rel, e.is_done, e.instr, e.slide, e.pc);
                end
            end
        end
    end

    task automatic push_issue(input int rel, input logic [15:0] ins, input bit sl, input logic [7:0] p);
        ev_t e;
        e.is_done = 1'b0; e.rel = rel; e.instr = ins; e.slide = sl; e.pc = p;
        sb.push_back(e);
    endtask

    task automatic push_done(input int rel, input logic [7:0] p);
        ev_t e;
        e.is_done = 1'b1; e.rel = rel; e.instr = '0; e.slide = 1'b0; e.pc = p;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [7:0] a);
        @(negedge clk);
        start = 1'b1;
        start_pc = a;
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic at_neg(input int n);
        do @(negedge clk); while ((cyc - t0) < n);
    endtask

    task automatic finish_test(input string name, input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL timeout_%s: %0d events outstanding, expected 0", name, sb.size());
            sb.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{16'h0000, 8'h10, 1, 4};
        vecs[1] = '{16'h2123, 8'h20, 1, 4};
        vecs[2] = '{16'h4ABC, 8'h30, 1, 4};
        vecs[3] = '{16'h8001, 8'h40, 1, 4};
        vecs[4] = '{16'hA005, 8'h50, 1, 4};
        vecs[5] = '{16'hC00F, 8'h60, 1, 4};
        vecs[6] = '{16'h6012, 8'h70, 1, 8};
        vecs[7] = '{16'h6855, 8'h80, 3, 16};
        vecs[8] = '{16'h7C01, 8'h90, 8, 36};
        vecs[9] = '{HALT,     8'hA0, 0, 2};
        for (int i = 0; i < 256; i++) mem[i] = HALT;

        repeat (3) @(negedge clk);
        chk("reset_pc", 32'(pc), 32'h0);
        chk("reset_issue_valid", 32'(issue_valid), 32'h0);
        chk("reset_issue_instr", 32'(issue_instr), 32'h0);
        chk("reset_slide_en", 32'(slide_en), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            mem[vecs[v].spc] = vecs[v].instr;
            mem[vecs[v].spc + 8'd1] = HALT;
            for (int k = 0; k < vecs[v].n_issue; k++)
                push_issue(2 + 4 * k, vecs[v].instr, k > 0, vecs[v].spc + 8'd1);
            push_done(vecs[v].done_rel, (vecs[v].n_issue == 0) ? vecs[v].spc : vecs[v].spc + 8'd1);
            do_start(vecs[v].spc);
            finish_test("vector", 60);
        end

        mem[8'h10] = 16'h2001; mem[8'h11] = 16'h4002; mem[8'h12] = HALT;
        push_issue(2, 16'h2001, 1'b0, 8'h11);
        push_issue(4, 16'h4002, 1'b0, 8'h12);
        push_done(6, 8'h12);
        do_start(8'h10);
        finish_test("ld_std_halt", 40);

        mem[8'hB0] = 16'h2077; mem[8'hB1] = HALT;
        push_issue(5, 16'h2077, 1'b0, 8'hB1);
        push_done(7, 8'hB1);
        do_start(8'hB0);
        at_neg(1); hold = 1'b1;
        at_neg(2); chk("hold_pc_frozen_a", 32'(pc), 32'hB0);
        at_neg(3); chk("hold_pc_frozen_b", 32'(pc), 32'hB0);
        at_neg(4); hold = 1'b0;
        finish_test("hold_exec", 40);

        mem[8'hC0] = 16'h6401; mem[8'hC1] = HALT;
        push_issue(2, 16'h6401, 1'b0, 8'hC1);
        push_issue(6, 16'h6401, 1'b1, 8'hC1);
        push_done(12, 8'hC1);
        do_start(8'hC0);
        at_neg(2); hold = 1'b1;
        at_neg(5); hold = 1'b0;
        finish_test("hold_occ_busy", 40);

        push_issue(2, 16'h6401, 1'b0, 8'hC1);
        push_issue(8, 16'h6401, 1'b1, 8'hC1);
        push_done(14, 8'hC1);
        do_start(8'hC0);
        at_neg(5); hold = 1'b1;
        at_neg(7); hold = 1'b0;
        finish_test("hold_occ_zero", 40);

        mem[8'hFF] = 16'h0000; mem[8'h00] = HALT;
        push_issue(2, 16'h0000, 1'b0, 8'h00);
        push_done(4, 8'h00);
        do_start(8'hFF);
        finish_test("pc_wrap", 40);

        mem[8'hD0] = 16'h6855; mem[8'hD1] = HALT;
        mem[8'hE0] = 16'h2AAA;
        push_issue(2, 16'h6855, 1'b0, 8'hD1);
        push_issue(6, 16'h6855, 1'b1, 8'hD1);
        push_issue(10, 16'h6855, 1'b1, 8'hD1);
        push_done(16, 8'hD1);
        do_start(8'hD0);
        at_neg(5); start = 1'b1; start_pc = 8'hE0;
        at_neg(6); start = 1'b0;
        finish_test("start_busy", 40);

        push_issue(2, 16'h6855, 1'b0, 8'hD1);
        do_start(8'hD0);
        at_neg(4); rst = 1'b1;
        #1;
        chk("midrst_pc", 32'(pc), 32'h0);
        chk("midrst_issue_valid", 32'(issue_valid), 32'h0);
        chk("midrst_issue_instr", 32'(issue_instr), 32'h0);
        chk("midrst_slide_en", 32'(slide_en), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        at_neg(5); rst = 1'b0;
        at_neg(25);
        chk("midrst_no_more_events", 32'(sb.size()), 32'h0);
        sb.delete();

        mem[8'h60] = 16'h2055; mem[8'h61] = HALT;
        push_issue(2, 16'h2055, 1'b0, 8'h61);
        push_done(4, 8'h61);
        do_start(8'h60);
        finish_test("after_rst", 40);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
